// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared opcode, exception-code and address-map definitions
package cpu_defs;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] ADDR_DM_END    = 32'h0000_3000;
    localparam logic [31:0] ADDR_TMR0_BASE = 32'h0000_7F00;
    localparam logic [31:0] ADDR_TMR1_BASE = 32'h0000_7F10;
    localparam logic [31:0] ADDR_IG_BASE   = 32'h0000_7F20;
    localparam logic [31:0] ADDR_EXC_PC    = 32'h0000_4180;

    localparam logic [31:0] TMR_WIN_BYTES  = 32'd12;
    localparam logic [31:0] IG_WIN_BYTES   = 32'd4;
    localparam logic [31:0] TMR_COUNT_OFS  = 32'd8;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } acc_size_e;

    // Half-open window test: base <= addr < base + bytes.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] bytes);
        return (addr >= base) && (addr < base + bytes);
    endfunction

endpackage

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - combinational load/store decode, lane shaping and address checks
module mem_access_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] DM_END    = ADDR_DM_END,
    parameter logic [31:0] TMR0_BASE = ADDR_TMR0_BASE,
    parameter logic [31:0] TMR1_BASE = ADDR_TMR1_BASE,
    parameter logic [31:0] IG_BASE   = ADDR_IG_BASE
) (
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] wsrc,
    input  logic [31:0] rdata,
    input  logic [4:0]  exccode_in,
    input  logic        exc_ov,
    input  logic        req,
    output logic [3:0]  byteen,
    output logic [31:0] wdata,
    output logic [4:0]  exccode,
    output logic [31:0] load_data,
    output logic        is_load
);

    logic        is_store;
    logic        sext;
    acc_size_e   size;
    logic [1:0]  lane;
    logic        misaligned;
    logic        in_dm;
    logic        in_dev;
    logic        to_count;
    logic        bad_addr;
    logic [3:0]  byteen_raw;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Decode the access kind, then judge the address and shape both data paths.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sext     = 1'b0;
        size     = SZ_WORD;
        case (opcode)
            OP_LW:  begin is_load  = 1'b1; size = SZ_WORD;              end
            OP_LH:  begin is_load  = 1'b1; size = SZ_HALF; sext = 1'b1; end
            OP_LHU: begin is_load  = 1'b1; size = SZ_HALF;              end
            OP_LB:  begin is_load  = 1'b1; size = SZ_BYTE; sext = 1'b1; end
            OP_LBU: begin is_load  = 1'b1; size = SZ_BYTE;              end
            OP_SW:  begin is_store = 1'b1; size = SZ_WORD;              end
            OP_SH:  begin is_store = 1'b1; size = SZ_HALF;              end
            OP_SB:  begin is_store = 1'b1; size = SZ_BYTE;              end
            default: ;
        endcase

        lane       = addr[1:0];
        misaligned = ((size == SZ_WORD) && (lane != 2'b00)) ||
                     ((size == SZ_HALF) && lane[0]);
        in_dm      = (addr < DM_END);
        in_dev     = in_window(addr, TMR0_BASE, TMR_WIN_BYTES) ||
                     in_window(addr, TMR1_BASE, TMR_WIN_BYTES) ||
                     in_window(addr, IG_BASE, IG_WIN_BYTES);
        // Timer count registers are read-only from software.
        to_count   = (addr == TMR0_BASE + TMR_COUNT_OFS) ||
                     (addr == TMR1_BASE + TMR_COUNT_OFS);
        bad_addr   = misaligned || exc_ov || !(in_dm || in_dev) ||
                     (in_dev && (size != SZ_WORD)) ||
                     (is_store && to_count);

        // Upstream exceptions are older and always take precedence.
        if (exccode_in != EXC_NONE)
            exccode = exccode_in;
        else if (is_load && bad_addr)
            exccode = EXC_ADEL;
        else if (is_store && bad_addr)
            exccode = EXC_ADES;
        else
            exccode = EXC_NONE;

        case (size)
            SZ_HALF: begin byteen_raw = 4'b0011 << lane; wdata = {2{wsrc[15:0]}}; end
            SZ_BYTE: begin byteen_raw = 4'b0001 << lane; wdata = {4{wsrc[7:0]}};  end
            default: begin byteen_raw = 4'b1111;         wdata = wsrc;            end
        endcase
        byteen = (is_store && !req && (exccode == EXC_NONE)) ? byteen_raw : 4'b0000;

        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        case (lane)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        case (size)
            SZ_HALF: load_data = {{16{sext & half_sel[15]}}, half_sel};
            SZ_BYTE: load_data = {{24{sext & byte_sel[7]}}, byte_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_wb_reg.sv
// rtl/mem_stage_wb_reg.sv - M stage bus interface and M/W pipeline register
module mem_stage_wb_reg
    import cpu_defs::*;
#(
    parameter logic [31:0] DM_END    = ADDR_DM_END,
    parameter logic [31:0] TMR0_BASE = ADDR_TMR0_BASE,
    parameter logic [31:0] TMR1_BASE = ADDR_TMR1_BASE,
    parameter logic [31:0] IG_BASE   = ADDR_IG_BASE,
    parameter logic [31:0] EXC_PC    = ADDR_EXC_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] m_ins,
    input  logic [4:0]  m_target_reg,
    input  logic [2:0]  m_t_new,
    input  logic [31:0] m_alu_ans,
    input  logic [31:0] m_write_data,
    input  logic [31:0] m_pcaddr,
    input  logic [4:0]  m_exccode_in,
    input  logic        m_exc_ov_dm,
    input  logic        m_bd,
    input  logic [31:0] m_rdata,
    output logic [31:0] m_addr,
    output logic [3:0]  m_byteen,
    output logic [31:0] m_wdata,
    output logic [4:0]  m_exccode,
    output logic        m_bd_out,
    output logic [31:0] w_ins,
    output logic [4:0]  w_target_reg,
    output logic [31:0] w_pcaddr,
    output logic [2:0]  w_t_new,
    output logic [31:0] w_data
);

    logic [31:0] load_data;
    logic        is_load;

    logic [31:0] w_ins_d,        w_ins_q;
    logic [4:0]  w_target_reg_d, w_target_reg_q;
    logic [31:0] w_pcaddr_d,     w_pcaddr_q;
    logic [2:0]  w_t_new_d,      w_t_new_q;
    logic [31:0] w_data_d,       w_data_q;

    mem_access_unit #(
        .DM_END    (DM_END),
        .TMR0_BASE (TMR0_BASE),
        .TMR1_BASE (TMR1_BASE),
        .IG_BASE   (IG_BASE)
    ) u_mau (
        .opcode     (m_ins[31:26]),
        .addr       (m_alu_ans),
        .wsrc       (m_write_data),
        .rdata      (m_rdata),
        .exccode_in (m_exccode_in),
        .exc_ov     (m_exc_ov_dm),
        .req        (req),
        .byteen     (m_byteen),
        .wdata      (m_wdata),
        .exccode    (m_exccode),
        .load_data  (load_data),
        .is_load    (is_load)
    );

    assign m_addr   = m_alu_ans;
    assign m_bd_out = m_bd;

    // Next M/W contents: a flush bubbles the stage and points W at the handler.
    always_comb begin
        w_ins_d        = m_ins;
        w_target_reg_d = m_target_reg;
        w_pcaddr_d     = m_pcaddr;
        w_t_new_d      = (m_t_new != 3'd0) ? m_t_new - 3'd1 : 3'd0;
        w_data_d       = is_load ? load_data : m_alu_ans;
        if (req) begin
            w_ins_d        = '0;
            w_target_reg_d = '0;
            w_pcaddr_d     = EXC_PC;
            w_t_new_d      = '0;
            w_data_d       = '0;
        end
    end

    // M/W register; reset overrides a simultaneous flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_ins_q        <= '0;
            w_target_reg_q <= '0;
            w_pcaddr_q     <= '0;
            w_t_new_q      <= '0;
            w_data_q       <= '0;
        end else begin
            w_ins_q        <= w_ins_d;
            w_target_reg_q <= w_target_reg_d;
            w_pcaddr_q     <= w_pcaddr_d;
            w_t_new_q      <= w_t_new_d;
            w_data_q       <= w_data_d;
        end
    end

    assign w_ins        = w_ins_q;
    assign w_target_reg = w_target_reg_q;
    assign w_pcaddr     = w_pcaddr_q;
    assign w_t_new      = w_t_new_q;
    assign w_data       = w_data_q;

endmodule

// File: tb/tb_mem_stage_wb_reg.sv
// tb/tb_mem_stage_wb_reg.sv - scoreboard bench for the M stage and M/W register
module tb_mem_stage_wb_reg;

    localparam logic [5:0] LW = 6'h23, LH = 6'h21, LHU = 6'h25, LB = 6'h20, LBU = 6'h24;
    localparam logic [5:0] SW = 6'h2B, SH = 6'h29, SB = 6'h28, NOP = 6'h00;

    logic        clk = 1'b0;
    logic        reset, req;
    logic [31:0] m_ins, m_alu_ans, m_write_data, m_pcaddr, m_rdata;
    logic [4:0]  m_target_reg, m_exccode_in;
    logic [2:0]  m_t_new;
    logic        m_exc_ov_dm, m_bd;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_byteen;
    logic [4:0]  m_exccode;
    logic        m_bd_out;
    logic [31:0] w_ins, w_pcaddr, w_data;
    logic [4:0]  w_target_reg;
    logic [2:0]  w_t_new;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [3:0]  byteen;
        logic [31:0] wdata;
        logic        chk_wdata;
        logic [4:0]  exccode;
        logic        bd;
        logic [31:0] w_ins;
        logic [4:0]  w_tgt;
        logic [31:0] w_pc;
        logic [2:0]  w_tnew;
        logic [31:0] w_data;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   vidx = 0;

    always #5 clk = ~clk;

    mem_stage_wb_reg dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .m_ins        (m_ins),
        .m_target_reg (m_target_reg),
        .m_t_new      (m_t_new),
        .m_alu_ans    (m_alu_ans),
        .m_write_data (m_write_data),
        .m_pcaddr     (m_pcaddr),
        .m_exccode_in (m_exccode_in),
        .m_exc_ov_dm  (m_exc_ov_dm),
        .m_bd         (m_bd),
        .m_rdata      (m_rdata),
        .m_addr       (m_addr),
        .m_byteen     (m_byteen),
        .m_wdata      (m_wdata),
        .m_exccode    (m_exccode),
        .m_bd_out     (m_bd_out),
        .w_ins        (w_ins),
        .w_target_reg (w_target_reg),
        .w_pcaddr     (w_pcaddr),
        .w_t_new      (w_t_new),
        .w_data       (w_data)
    );

    task automatic chk(input string vec, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s %s: got %h expected %h", vec, what, act, exp);
    endtask

    // Drive one vector at the falling edge and post its expected response.
    task automatic apply(input string name, input logic rst, input logic rq,
                         input logic [5:0] op, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input logic [4:0] excin, input logic ov, input logic [2:0] tnew,
                         input logic [3:0] e_be, input logic [31:0] e_wd, input logic chk_wd,
                         input logic [4:0] e_exc, input logic [31:0] e_wdata,
                         input logic [2:0] e_tnew);
        exp_t e;
        @(negedge clk);
        reset        = rst;
        req          = rq;
        m_ins        = {op, 26'h0A5_1234};
        m_target_reg = 5'(vidx + 1);
        m_t_new      = tnew;
        m_alu_ans    = alu;
        m_write_data = wd;
        m_pcaddr     = 32'h0000_3000 + 32'(vidx * 4);
        m_exccode_in = excin;
        m_exc_ov_dm  = ov;
        m_bd         = vidx[0];
        m_rdata      = rd;
        e.name      = name;
        e.addr      = alu;
        e.byteen    = e_be;
        e.wdata     = e_wd;
        e.chk_wdata = chk_wd;
        e.exccode   = e_exc;
        e.bd        = vidx[0];
        e.w_ins     = (rst || rq) ? 32'h0 : {op, 26'h0A5_1234};
        e.w_tgt     = (rst || rq) ? 5'd0 : 5'(vidx + 1);
        e.w_pc      = rst ? 32'h0 : (rq ? 32'h0000_4180 : 32'h0000_3000 + 32'(vidx * 4));
        e.w_tnew    = e_tnew;
        e.w_data    = e_wdata;
        exp_q.push_back(e);
        vidx++;
    endtask

    // Monitor: just after each rising edge the combinational outputs still show the
    // vector driven at the previous falling edge, and w_* hold what that edge captured.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "m_addr",    m_addr,             e.addr);
                chk(e.name, "m_byteen",  {28'h0, m_byteen},  {28'h0, e.byteen});
                if (e.chk_wdata) chk(e.name, "m_wdata", m_wdata, e.wdata);
                chk(e.name, "m_exccode", {27'h0, m_exccode}, {27'h0, e.exccode});
                chk(e.name, "m_bd_out",  {31'h0, m_bd_out},  {31'h0, e.bd});
                chk(e.name, "w_ins",     w_ins,              e.w_ins);
                chk(e.name, "w_target",  {27'h0, w_target_reg}, {27'h0, e.w_tgt});
                chk(e.name, "w_pcaddr",  w_pcaddr,           e.w_pc);
                chk(e.name, "w_t_new",   {29'h0, w_t_new},   {29'h0, e.w_tnew});
                chk(e.name, "w_data",    w_data,             e.w_data);
            end
        end
    end

    initial begin
        int waited;
        reset = 1'b1; req = 1'b0; m_ins = '0; m_target_reg = '0; m_t_new = '0;
        m_alu_ans = '0; m_write_data = '0; m_pcaddr = '0; m_exccode_in = '0;
        m_exc_ov_dm = 1'b0; m_bd = 1'b0; m_rdata = '0;

        //     name          rst rq  op   alu           wdata         rdata         excin ov tnew  be       m_wdata       chk exc    w_data        w_tnew
        apply("reset",       1, 0, NOP, 32'h1234_5678, 32'h0,        32'h0,        5'd0, 0, 3'd4, 4'b0000, 32'h0,        0, 5'd0,  32'h0,        3'd0);
        apply("sb_102",      0, 0, SB,  32'h0000_0102, 32'h0000_00AB, 32'h0,       5'd0, 0, 3'd2, 4'b0100, 32'hABAB_ABAB, 1, 5'd0, 32'h0000_0102, 3'd1);
        apply("lh_2",        0, 0, LH,  32'h0000_0002, 32'h0,        32'h8001_1234, 5'd0, 0, 3'd0, 4'b0000, 32'h0,        0, 5'd0,  32'hFFFF_8001, 3'd0);
        apply("lhu_2",       0, 0, LHU, 32'h0000_0002, 32'h0,        32'h8001_1234, 5'd0, 0, 3'd3, 4'b0000, 32'h0,        0, 5'd0,  32'h0000_8001, 3'd2);
        apply("lw_mis",      0, 0, LW,  32'h0000_0006, 32'h0,        32'hDEAD_BEEF, 5'd0, 0, 3'd1, 4'b0000, 32'h0,        0, 5'd4,  32'hDEAD_BEEF, 3'd0);
        apply("sw_count",    0, 0, SW,  32'h0000_7F08, 32'h1111_1111, 32'h0,       5'd0, 0, 3'd0, 4'b0000, 32'h1111_1111, 1, 5'd5, 32'h0000_7F08, 3'd0);
        apply("sb_ig",       0, 0, SB,  32'h0000_7F20, 32'h0000_0011, 32'h0,       5'd0, 0, 3'd0, 4'b0000, 32'h1111_1111, 1, 5'd5, 32'h0000_7F20, 3'd0);
        apply("sw_upstream", 0, 0, SW,  32'h0000_0005, 32'h2222_2222, 32'h0,       5'd12, 0, 3'd0, 4'b0000, 32'h2222_2222, 1, 5'd12, 32'h0000_0005, 3'd0);
        apply("sw_req",      0, 1, SW,  32'h0000_0010, 32'hCAFE_F00D, 32'h0,       5'd0, 0, 3'd5, 4'b0000, 32'hCAFE_F00D, 1, 5'd0, 32'h0,        3'd0);
        apply("lb_3",        0, 0, LB,  32'h0000_0003, 32'h0,        32'h80AA_5500, 5'd0, 0, 3'd7, 4'b0000, 32'h0,        0, 5'd0,  32'hFFFF_FF80, 3'd6);
        apply("lbu_1",       0, 0, LBU, 32'h0000_0001, 32'h0,        32'h80AA_5500, 5'd0, 0, 3'd1, 4'b0000, 32'h0,        0, 5'd0,  32'h0000_0055, 3'd0);
        apply("sw_dm_top",   0, 0, SW,  32'h0000_2FFC, 32'h0102_0304, 32'h0,       5'd0, 0, 3'd0, 4'b1111, 32'h0102_0304, 1, 5'd0, 32'h0000_2FFC, 3'd0);
        apply("sh_2",        0, 0, SH,  32'h0000_0002, 32'h1234_BEEF, 32'h0,       5'd0, 0, 3'd0, 4'b1100, 32'hBEEF_BEEF, 1, 5'd0, 32'h0000_0002, 3'd0);
        apply("sw_dm_end",   0, 0, SW,  32'h0000_3000, 32'h0,        32'h0,        5'd0, 0, 3'd0, 4'b0000, 32'h0,        0, 5'd5,  32'h0000_3000, 3'd0);
        apply("lw_gap",      0, 0, LW,  32'h0000_7F0C, 32'h0,        32'hA5A5_A5A5, 5'd0, 0, 3'd0, 4'b0000, 32'h0,        0, 5'd4,  32'hA5A5_A5A5, 3'd0);
        apply("lw_count",    0, 0, LW,  32'h0000_7F08, 32'h0,        32'h0000_0042, 5'd0, 0, 3'd0, 4'b0000, 32'h0,        0, 5'd0,  32'h0000_0042, 3'd0);
        apply("lw_ov",       0, 0, LW,  32'h0000_0000, 32'h0,        32'h0000_0001, 5'd0, 1, 3'd0, 4'b0000, 32'h0,        0, 5'd4,  32'h0000_0001, 3'd0);
        apply("lb_timer",    0, 0, LB,  32'h0000_7F00, 32'h0,        32'h0000_00FF, 5'd0, 0, 3'd0, 4'b0000, 32'h0,        0, 5'd4,  32'hFFFF_FFFF, 3'd0);
        apply("nonmem",      0, 0, NOP, 32'hFFFF_0000, 32'h0,        32'h0,        5'd0, 0, 3'd1, 4'b0000, 32'h0,        0, 5'd0,  32'hFFFF_0000, 3'd0);
        apply("sw_tmr1",     0, 0, SW,  32'h0000_7F14, 32'h5A5A_0000, 32'h0,       5'd0, 0, 3'd0, 4'b1111, 32'h5A5A_0000, 1, 5'd0, 32'h0000_7F14, 3'd0);
        apply("reset_req",   1, 1, NOP, 32'h0000_0077, 32'h0,        32'h0,        5'd0, 0, 3'd3, 4'b0000, 32'h0,        0, 5'd0,  32'h0,        3'd0);

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        total_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("FAIL drain: %0d responses still pending, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
